stopwatch_ctrl: RTL and testbench

Run-control stage that sits directly upstream of the seconds counter. It debounces two raw push-buttons, start/stop and clear, and runs an IDLE/RUN/PAUSE state machine. It divides clk down to a single-cycle 1 Hz `tick_en` pulse, which drives the counter's `enable`. It also issues a single-cycle `cnt_clear` pulse, which drives the counter's synchronous `reset`.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_btn_debounce.sv | 54 +++++
 rtl/stopwatch_ctrl.sv | 135 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch chain: run-control state encoding and
// default timing parameters. The seconds/minutes stages downstream import
// this same package so every stage agrees on the state encoding.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // clk cycles per 1 Hz tick at a 100 MHz system clock
    localparam int DEF_CLK_DIV         = 100_000_000;
    // 10 ms of stable level at 100 MHz before a button change is accepted
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce
// Conditions one raw push-button: 2-flop synchronizer, counting debouncer,
// and a one-cycle pulse on each accepted 0->1 change of the stable level.
//
// Ports
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   btn_raw : raw button, asynchronous to clk, active-high
//   level   : debounced stable level
//   press   : one-cycle pulse when level flips 0->1 (registered)
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // The counter flips the level on the same edge it would have reached
    // DEBOUNCE_CYCLES, so it never actually stores that value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Run-control stage in front of the seconds counter. Debounces the start/stop
// and clear buttons, runs the IDLE/RUN/PAUSE machine and divides clk down to
// a one-cycle tick that enables the counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | stopped and cleared; prescaler held at 0
//   RUN      | prescaler counting, tick_en every CLK_DIV cycles
//   PAUSE    | stopped; prescaler holds its partial period for resume
//   (2'b11)  | unreachable; falls back to IDLE silently
//
// Ports
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   btn_start_stop : raw start/stop button (async, active-high)
//   btn_clear      : raw clear button (async, active-high)
//   tick_en        : one-cycle pulse per elapsed tick period in RUN
//   cnt_clear      : one-cycle pulse zeroing downstream counters
//   running        : high while in RUN
//   state          : current FSM state
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV         = DEF_CLK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       tick_en,
    output logic       cnt_clear,
    output logic       running,
    output logic [1:0] state
);

    localparam int PW = $clog2(CLK_DIV);

    logic ss_press;
    logic clr_press;
    logic ss_level_unused;
    logic clr_level_unused;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_start_stop (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_start_stop),
        .level  (ss_level_unused),
        .press  (ss_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_clear),
        .level  (clr_level_unused),
        .press  (clr_press)
    );

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_d;
    logic          clear_d;
    logic          presc_last;

    assign presc_last = (presc_q == PW'(CLK_DIV - 1));

    // Clear outranks everything, including a start/stop press in the same
    // cycle and a tick that would otherwise fire on the wrap.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;
        if (state_q == ST_ILLEGAL) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else if (clr_press) begin
            state_d = ST_IDLE;
            presc_d = '0;
            clear_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (ss_press) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Counting continues on the pause cycle so a tick due on
                    // that cycle is still delivered.
                    if (presc_last) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                    if (ss_press) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (ss_press) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tick_en   <= 1'b0;
            cnt_clear <= 1'b0;
            running   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_en   <= tick_d;
            cnt_clear <= clear_d;
            running   <= (state_d == ST_RUN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with CLK_DIV=10, DEBOUNCE_CYCLES=4.
// Expected tick_en / cnt_clear pulses are queued with their cycle number as
// stimulus is driven; a monitor pops and compares every pulse the DUT emits.
module tb_stopwatch_ctrl;

    localparam int CD = 10;
    localparam int DB = 4;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       tick_en;
    logic       cnt_clear;
    logic       running;
    logic [1:0] state;

    stopwatch_ctrl #(
        .CLK_DIV        (CD),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
        .tick_en       (tick_en),
        .cnt_clear     (cnt_clear),
        .running       (running),
        .state         (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_clear;
        int at;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;
    int  n_checks = 0;
    int  n_fail = 0;

    // bench-side expectation of the run state: 0 idle, 1 run, 2 pause
    int mst = 0;
    int next_tick = 0;
    int hp = 0;

    always @(negedge clk) begin
        if (tick_en || cnt_clear) begin
            n_checks++;
            if (tick_en && cnt_clear) begin
                n_fail++;
                $display("FAIL exclusive: tick_en=1 and cnt_clear=1 at cycle %0d, required at most one", cyc);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: tick_en=%0b cnt_clear=%0b at cycle %0d, required no pulse",
                         tick_en, cnt_clear, cyc);
            end else begin
                mon_ev = sb.pop_front();
                if (mon_ev.is_clear !== cnt_clear || mon_ev.at != cyc) begin
                    n_fail++;
                    $display("FAIL pulse_sb: got %s at cycle %0d, required %s at cycle %0d",
                             cnt_clear ? "cnt_clear" : "tick_en", cyc,
                             mon_ev.is_clear ? "cnt_clear" : "tick_en", mon_ev.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required $finish before it");
        $fatal(1, "timeout");
    end

    // Advance n cycles (negedge to negedge), queueing every tick due in that window.
    task automatic advance(input int n);
        int e;
        e = cyc + n;
        while (mst == 1 && next_tick <= e) begin
            sb.push_back('{is_clear: 1'b0, at: next_tick});
            next_tick += CD;
        end
        repeat (n) @(negedge clk);
    endtask

    // Advance until the next expected tick is a cycles away.
    task automatic align(input int a);
        int g;
        g = 0;
        while (next_tick - cyc != a && g < 2 * CD) begin
            advance(1);
            g++;
        end
    endtask

    // Clean start/stop press: state changes on the 7th edge after the raise.
    task automatic press_ss();
        btn_start_stop = 1'b1;
        advance(DB + 3);
        btn_start_stop = 1'b0;
        if (mst == 1) begin
            hp  = (CD - (next_tick - cyc)) % CD;
            mst = 2;
        end else begin
            if (mst == 0) hp = 0;
            mst       = 1;
            next_tick = cyc + CD - hp;
        end
        advance(DB + 4);
    endtask

    // Clean clear press (optionally with start/stop on the same cycles).
    task automatic press_clr(input bit with_ss);
        btn_clear = 1'b1;
        if (with_ss) btn_start_stop = 1'b1;
        advance(DB + 2);
        sb.push_back('{is_clear: 1'b1, at: cyc + 1});
        mst = 0;
        hp  = 0;
        advance(1);
        btn_clear      = 1'b0;
        btn_start_stop = 1'b0;
        advance(DB + 4);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({state, running, tick_en, cnt_clear} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%b, required 00000", {state, running, tick_en, cnt_clear});
        end
        rst_n = 1'b1;
        advance(6);
        n_checks++;
        if ({state, running, tick_en, cnt_clear} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs=%b, required 00000", {state, running, tick_en, cnt_clear});
        end
    endtask

    task automatic test_start();
        btn_start_stop = 1'b1;
        advance(DB + 2);
        n_checks++;
        if (state !== S_IDLE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL start_early: state=%b running=%b, required 00/0", state, running);
        end
        advance(1);
        n_checks++;
        if (state !== S_RUN || running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: state=%b running=%b, required 01/1", state, running);
        end
        btn_start_stop = 1'b0;
        mst       = 1;
        hp        = 0;
        next_tick = cyc + CD;
        advance(DB + 4);
        advance(3 * CD);
    endtask

    task automatic test_bounce();
        bit pat[];
        pat = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        foreach (pat[i]) begin
            btn_clear = pat[i];
            advance(1);
        end
        btn_clear = 1'b0;
        advance(12);
        n_checks++;
        if (state !== S_RUN || running !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_state: state=%b running=%b, required 01/1", state, running);
        end
    endtask

    task automatic test_pause_resume();
        align(1);
        press_ss();
        n_checks++;
        if (state !== S_PAUSE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_state: state=%b running=%b, required 10/0", state, running);
        end
        advance(3 * CD);
        n_checks++;
        if (state !== S_PAUSE) begin
            n_fail++;
            $display("FAIL pause_hold: state=%b, required 10", state);
        end
        // prescaler was left holding 6, so the first tick comes 4 cycles in
        btn_start_stop = 1'b1;
        advance(DB + 3);
        btn_start_stop = 1'b0;
        n_checks++;
        if (state !== S_RUN || running !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_state: state=%b running=%b, required 01/1", state, running);
        end
        mst       = 1;
        next_tick = cyc + 4;
        advance(DB + 4);
        advance(2 * CD);
    endtask

    task automatic test_clear();
        advance(3);
        press_clr(1'b0);
        n_checks++;
        if (state !== S_IDLE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_run: state=%b running=%b, required 00/0", state, running);
        end
        press_ss();
        advance(12);
        press_ss();
        n_checks++;
        if (state !== S_PAUSE) begin
            n_fail++;
            $display("FAIL clear_prep_pause: state=%b, required 10", state);
        end
        press_clr(1'b0);
        n_checks++;
        if (state !== S_IDLE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_pause: state=%b running=%b, required 00/0", state, running);
        end
        press_clr(1'b0);
        n_checks++;
        if (state !== S_IDLE) begin
            n_fail++;
            $display("FAIL clear_idle: state=%b, required 00", state);
        end
        press_ss();
        advance(2 * CD);
    endtask

    task automatic test_collisions();
        press_clr(1'b1);
        n_checks++;
        if (state !== S_IDLE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_both: state=%b running=%b, required 00/0", state, running);
        end
        press_ss();
        advance(5);
        align(DB + 3);
        press_ss();
        n_checks++;
        if (state !== S_PAUSE) begin
            n_fail++;
            $display("FAIL coll_ss_wrap: state=%b, required 10", state);
        end
        press_ss();
        advance(5);
        align(DB + 3);
        press_clr(1'b0);
        n_checks++;
        if (state !== S_IDLE) begin
            n_fail++;
            $display("FAIL coll_clr_wrap: state=%b, required 00", state);
        end
    endtask

    task automatic test_async_reset();
        press_ss();
        advance(4);
        align(5);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({state, running, tick_en, cnt_clear} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%b, required 00000", {state, running, tick_en, cnt_clear});
        end
        mst = 0;
        hp  = 0;
        advance(3);
        rst_n = 1'b1;
        advance(3 * CD);
        n_checks++;
        if (state !== S_IDLE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: state=%b running=%b, required 00/0", state, running);
        end
        // button held through reset release is taken as a fresh press
        rst_n = 1'b0;
        btn_start_stop = 1'b1;
        advance(2);
        rst_n = 1'b1;
        advance(DB + 2);
        n_checks++;
        if (state !== S_IDLE) begin
            n_fail++;
            $display("FAIL held_btn_early: state=%b, required 00", state);
        end
        advance(1);
        n_checks++;
        if (state !== S_RUN) begin
            n_fail++;
            $display("FAIL held_btn_run: state=%b, required 01", state);
        end
        btn_start_stop = 1'b0;
        mst       = 1;
        next_tick = cyc + CD;
        advance(DB + 4);
        press_clr(1'b0);
    endtask

    initial begin
        test_reset();
        test_start();
        test_bounce();
        test_pause_resume();
        test_clear();
        test_collisions();
        test_async_reset();
        advance(2 * CD);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected pulses never seen, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
